key_schedule_iter: RTL and testbench

- Iterative AES-128 key expansion stage, directly downstream of the round-constant generator.
- Consumes the ten Rcon bytes that the generator produces and a 128-bit cipher key.
- Emits round keys 0..NUM_ROUNDS one per accepted transfer over a valid/ready handshake to the cipher datapath.
- One round-key derivation per cycle, using four parallel internal S-box lookups (SubWord).

---
 rtl/key_schedule_iter.sv | 166 ++++++++++++++++
 tb/tb_key_schedule_iter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : key_schedule_iter
//  Purpose  : Iterative AES-128 key expansion, one round key per accepted
//             valid/ready transfer. Optional round-key store: KEY_STORE_EN.
//  Revision : 1.0
// ============================================================================
module key_schedule_iter #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         i_Reset,
  input  logic         i_Start,
  input  logic [127:0] i_Key,
  input  logic [79:0]  i_Rcon,
  input  logic         i_Ready,
  output logic [127:0] o_Round_Key,
  output logic [3:0]   o_Round_Index,
  output logic         o_Key_Valid,
  output logic         o_Busy,
  output logic         o_Done,
  input  logic [3:0]   i_Rd_Addr,
  output logic [127:0] o_Rd_Key
);

  localparam logic [3:0] c_LAST = 4'(NUM_ROUNDS);

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    return c_SBOX[(11'd2047 - {x, 3'b000}) -: 8];
  endfunction

  function automatic logic [31:0] f_subword(input logic [31:0] w);
    return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
  endfunction

  state_t         r_State;
  logic [127:0]   r_Round_Key;
  logic [3:0]     r_Index;
  logic           r_Valid;
  logic           r_Busy;
  logic           r_Done;

  logic [7:0]     w_Rcon_Bytes [0:15];
  logic [31:0]    w_W0, w_W1, w_W2, w_W3;
  logic [31:0]    w_T;
  logic [31:0]    w_N0, w_N1, w_N2, w_N3;
  logic [127:0]   w_Next_Key;
  logic           w_Load;
  logic           w_Advance;
  logic           w_Finish;

  // Pad the Rcon table to 16 entries so any 4-bit index is in range.
  generate
    for (genvar k = 0; k < 16; k++) begin : g_rcon
      if (k < 10) begin : g_used
        assign w_Rcon_Bytes[k] = i_Rcon[8*k +: 8];
      end else begin : g_pad
        assign w_Rcon_Bytes[k] = 8'h00;
      end
    end
  endgenerate

  assign {w_W0, w_W1, w_W2, w_W3} = r_Round_Key;
  assign w_T  = f_subword({w_W3[23:0], w_W3[31:24]}) ^ {w_Rcon_Bytes[r_Index], 24'h000000};
  assign w_N0 = w_W0 ^ w_T;
  assign w_N1 = w_W1 ^ w_N0;
  assign w_N2 = w_W2 ^ w_N1;
  assign w_N3 = w_W3 ^ w_N2;
  assign w_Next_Key = {w_N0, w_N1, w_N2, w_N3};

  assign w_Load    = (r_State == S_IDLE) && i_Start;
  assign w_Advance = (r_State == S_EMIT) && i_Ready && (r_Index != c_LAST);
  assign w_Finish  = (r_State == S_EMIT) && i_Ready && (r_Index == c_LAST);

  always_ff @(posedge clk) begin
    if (i_Reset) begin
      r_State     <= S_IDLE;
      r_Round_Key <= '0;
      r_Index     <= '0;
      r_Valid     <= 1'b0;
      r_Busy      <= 1'b0;
      r_Done      <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (w_Load) begin
            r_Round_Key <= i_Key;
            r_Index     <= '0;
            r_Valid     <= 1'b1;
            r_Busy      <= 1'b1;
            r_State     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_Finish) begin
            r_Valid <= 1'b0;
            r_Busy  <= 1'b0;
            r_Done  <= 1'b1;
            r_State <= S_IDLE;
          end else if (w_Advance) begin
            r_Round_Key <= w_Next_Key;
            r_Index     <= r_Index + 4'd1;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Round_Key   = r_Round_Key;
  assign o_Round_Index = r_Index;
  assign o_Key_Valid   = r_Valid;
  assign o_Busy        = r_Busy;
  assign o_Done        = r_Done;

`ifdef KEY_STORE_EN
  logic [127:0] r_Store [0:10];

  always_ff @(posedge clk) begin
    if (i_Reset) begin
      for (int k = 0; k < 11; k++) begin
        r_Store[k] <= '0;
      end
    end else if (w_Load) begin
      r_Store[0] <= i_Key;
    end else if (w_Advance) begin
      r_Store[r_Index + 4'd1] <= w_Next_Key;
    end
  end

  assign o_Rd_Key = (i_Rd_Addr <= c_LAST) ? r_Store[i_Rd_Addr] : '0;
`else
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = ^i_Rd_Addr;
  assign o_Rd_Key         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_key_schedule_iter
//  Purpose  : Scoreboard bench for key_schedule_iter using FIPS-197 vectors.
//  Revision : 1.0
// ============================================================================
module tb_key_schedule_iter;

  logic         clk = 1'b0;
  logic         i_Reset = 1'b1;
  logic         i_Start = 1'b0;
  logic [127:0] i_Key = '0;
  logic [79:0]  i_Rcon = 80'h361b8040201008040201;
  logic         i_Ready = 1'b1;
  logic [3:0]   i_Rd_Addr = '0;
  wire  [127:0] o_Round_Key;
  wire  [3:0]   o_Round_Index;
  wire          o_Key_Valid;
  wire          o_Busy;
  wire          o_Done;
  wire  [127:0] o_Rd_Key;

  key_schedule_iter #(.NUM_ROUNDS(10)) dut (
    .clk           (clk),
    .i_Reset       (i_Reset),
    .i_Start       (i_Start),
    .i_Key         (i_Key),
    .i_Rcon        (i_Rcon),
    .i_Ready       (i_Ready),
    .o_Round_Key   (o_Round_Key),
    .o_Round_Index (o_Round_Index),
    .o_Key_Valid   (o_Key_Valid),
    .o_Busy        (o_Busy),
    .o_Done        (o_Done),
    .i_Rd_Addr     (i_Rd_Addr),
    .o_Rd_Key      (o_Rd_Key)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         q[$];
  logic [127:0] fips [0:10];
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [3:0] idx, input logic [127:0] key);
    exp_t e;
    e.idx = idx;
    e.key = key;
    q.push_back(e);
  endtask

  task automatic push_fips();
    for (int i = 0; i <= 10; i++) push_exp(4'(i), fips[i]);
  endtask

  task automatic wait_index(input logic [3:0] idx);
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk); #1;
      if (o_Key_Valid && o_Round_Index == idx) ok = 1'b1;
    end
    chk("wait_index", {127'd0, ok}, 128'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk); #1;
      if (o_Done) ok = 1'b1;
    end
    chk("wait_done", {127'd0, ok}, 128'd1);
  endtask

  // Monitor: pops on every accepted transfer and checks stall stability.
  exp_t         m_e;
  logic         m_prev_stall = 1'b0;
  logic [127:0] m_prev_key;
  logic [3:0]   m_prev_idx;

  always @(negedge clk) begin
    if (i_Reset) begin
      m_prev_stall = 1'b0;
    end else begin
      if (m_prev_stall) begin
        chk("stall_key", o_Round_Key, m_prev_key);
        chk("stall_index", {124'd0, o_Round_Index}, {124'd0, m_prev_idx});
        chk("stall_valid", {127'd0, o_Key_Valid}, 128'd1);
      end
      if (o_Key_Valid && i_Ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", {124'd0, o_Round_Index}, 128'hffff);
        end else begin
          m_e = q.pop_front();
          chk("sb_index", {124'd0, o_Round_Index}, {124'd0, m_e.idx});
          chk("sb_key", o_Round_Key, m_e.key);
        end
      end
      m_prev_stall = o_Key_Valid && !i_Ready;
      m_prev_key   = o_Round_Key;
      m_prev_idx   = o_Round_Index;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    repeat (3) @(posedge clk);
    #1 i_Reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {127'd0, o_Key_Valid}, 128'd0);
    chk("rst_busy", {127'd0, o_Busy}, 128'd0);
    chk("rst_done", {127'd0, o_Done}, 128'd0);
    chk("rst_index", {124'd0, o_Round_Index}, 128'd0);
    chk("rst_key", o_Round_Key, 128'd0);
    chk("rst_rdkey", o_Rd_Key, 128'd0);

    // FIPS run with full-throughput timing
    push_fips();
    @(posedge clk); #1;
    i_Key = fips[0];
    i_Start = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      i_Start = 1'b0;
      @(negedge clk);
      if (n <= 11) begin
        chk("t_valid", {127'd0, o_Key_Valid}, 128'd1);
        chk("t_index", {124'd0, o_Round_Index}, 128'(n - 1));
        chk("t_nodone", {127'd0, o_Done}, 128'd0);
        chk("t_busy", {127'd0, o_Busy}, 128'd1);
      end else if (n == 12) begin
        chk("t_done", {127'd0, o_Done}, 128'd1);
        chk("t_end_valid", {127'd0, o_Key_Valid}, 128'd0);
        chk("t_end_busy", {127'd0, o_Busy}, 128'd0);
      end else begin
        chk("t_done_pulse", {127'd0, o_Done}, 128'd0);
      end
    end
    chk("q_empty_1", 128'(q.size()), 128'd0);

    // Round-key store read-back
`ifdef KEY_STORE_EN
    i_Rd_Addr = 4'd10; #1;
    chk("store_10", o_Rd_Key, fips[10]);
    i_Rd_Addr = 4'd0; #1;
    chk("store_0", o_Rd_Key, fips[0]);
    i_Rd_Addr = 4'd5; #1;
    chk("store_5", o_Rd_Key, fips[5]);
    i_Rd_Addr = 4'd12; #1;
    chk("store_12", o_Rd_Key, 128'd0);
`else
    for (int a = 0; a < 16; a += 5) begin
      i_Rd_Addr = 4'(a); #1;
      chk("store_off", o_Rd_Key, 128'd0);
    end
`endif
    i_Rd_Addr = 4'd0;

    // Backpressure at index 4, ignored start at index 5
    push_fips();
    @(posedge clk); #1;
    i_Key = fips[0];
    i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    wait_index(4'd4);
    i_Ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("bp_index", {124'd0, o_Round_Index}, 128'd4);
      chk("bp_key", o_Round_Key, fips[4]);
    end
    @(posedge clk); #1;
    i_Ready = 1'b1;
    wait_index(4'd5);
    i_Key = 128'd0;
    i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    wait_done();
    chk("q_empty_2", 128'(q.size()), 128'd0);

    // Back-to-back start in the done cycle
    i_Key = fips[0];
    i_Start = 1'b1;
    push_fips();
    @(posedge clk); #1;
    i_Start = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {127'd0, o_Key_Valid}, 128'd1);
    chk("b2b_index", {124'd0, o_Round_Index}, 128'd0);
    chk("b2b_busy", {127'd0, o_Busy}, 128'd1);
    chk("b2b_done", {127'd0, o_Done}, 128'd0);

    // Reset mid-schedule at index 6
    wait_index(4'd6);
    i_Reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    i_Reset = 1'b0;
    @(negedge clk);
    chk("mr_valid", {127'd0, o_Key_Valid}, 128'd0);
    chk("mr_busy", {127'd0, o_Busy}, 128'd0);
    chk("mr_index", {124'd0, o_Round_Index}, 128'd0);
    chk("mr_key", o_Round_Key, 128'd0);
    for (int s = 0; s < 3; s++) begin
      chk("mr_nodone", {127'd0, o_Done}, 128'd0);
      @(negedge clk);
    end

    // All-zero key
    push_exp(4'd0, 128'd0);
    push_exp(4'd1, 128'h62636363626363636263636362636363);
    push_exp(4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    @(posedge clk); #1;
    i_Key = 128'd0;
    i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    wait_index(4'd3);
    i_Reset = 1'b1;
    chk("q_empty_3", 128'(q.size()), 128'd0);
    q.delete();
    @(posedge clk); #1;
    i_Reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
